// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Constants and types shared by the router port serializer, the matching
// input-port deserializer and the testbench.
//   NUM_PORTS       : number of router ports
//   BYTE_W          : payload byte width
//   GAP_CYCLES_DEF  : default idle cycles forced after each packet
//   STALL_MAX_DEF   : default bubble limit inside a packet before abort
//   tx_state_e      : output-port serializer states
// ---------------------------------------------------------------------------
package router_pkg;

   localparam int NUM_PORTS     = 16;
   localparam int BYTE_W        = 8;
   localparam int GAP_CYCLES_DEF = 2;
   localparam int STALL_MAX_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } tx_state_e;

endpackage : router_pkg

// File: rtl/router_oport_tx.sv
// ---------------------------------------------------------------------------
// router_oport_tx
// Per-output-port serializer. Accepts bytes on a valid/ready/last stream and
// shifts them out LSB first on the router's serial output protocol.
//
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       : byte handshake (see below)
//   in_data, in_last        : payload byte and end-of-packet flag
//   dout                    : serial data, LSB first
//   valido_n                : active-low, dout carries a payload bit
//   frameo_n                : active-low, packet in progress; high on last bit
//   err_underrun            : one-cycle pulse when a packet is aborted
//   pkt_cnt                 : packets completed normally (wraps)
//   dbg_state               : current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready are
// both high. in_ready is registered; while it is low in_valid, in_data and
// in_last are ignored, and the source must hold them stable until accepted.
//
// Every output is a register loaded from the next-state values, so the
// outputs always describe the state the FSM is in during the current cycle.
// ---------------------------------------------------------------------------
module router_oport_tx
   import router_pkg::*;
#(
   parameter int GAP_CYCLES = GAP_CYCLES_DEF,
   parameter int STALL_MAX  = STALL_MAX_DEF,
   parameter int CNT_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              dout,
   output logic              valido_n,
   output logic              frameo_n,
   output logic              err_underrun,
   output logic [CNT_W-1:0]  pkt_cnt,
   output tx_state_e         dbg_state
);

   localparam int STALL_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX);
   localparam int GAP_W   = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_MAX > 0) ? STALL_MAX - 1 : 0);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [2:0]         BIT_LAST   = 3'(BYTE_W - 1);

   // With no forced gap, a finished or aborted packet returns straight to IDLE.
   localparam tx_state_e END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

   tx_state_e           r_state;
   logic [2:0]          r_bit;
   logic [BYTE_W-1:0]   r_sh;
   logic                r_last;
   logic [STALL_W-1:0]  r_stall;
   logic [GAP_W-1:0]    r_gap;
   logic                r_in_ready;
   logic                r_dout;
   logic                r_valido_n;
   logic                r_frameo_n;
   logic                r_err;
   logic [CNT_W-1:0]    r_pkt_cnt;

   tx_state_e           w_state_nxt;
   logic [2:0]          w_bit_nxt;
   logic [BYTE_W-1:0]   w_sh_nxt;
   logic                w_last_nxt;
   logic [STALL_W-1:0]  w_stall_nxt;
   logic [GAP_W-1:0]    w_gap_nxt;
   logic [CNT_W-1:0]    w_pkt_nxt;
   logic                w_err_nxt;
   logic                w_accept;
   logic                w_in_ready_nxt;
   logic                w_dout_nxt;
   logic                w_valido_n_nxt;
   logic                w_frameo_n_nxt;

   assign w_accept = in_valid & r_in_ready;

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit;
      w_sh_nxt    = r_sh;
      w_last_nxt  = r_last;
      w_stall_nxt = r_stall;
      w_gap_nxt   = r_gap;
      w_pkt_nxt   = r_pkt_cnt;
      w_err_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_bit_nxt   = 3'd0;
               w_sh_nxt    = in_data;
               w_last_nxt  = in_last;
            end
         end

         SHIFT: begin
            if (r_bit != BIT_LAST) begin
               w_bit_nxt = r_bit + 3'd1;
            end else if (r_last) begin
               w_state_nxt = END_STATE;
               w_gap_nxt   = '0;
               w_pkt_nxt   = r_pkt_cnt + 1'b1;
            end else if (w_accept) begin
               // Back-to-back byte: bit0 follows bit7 with no bubble.
               w_bit_nxt  = 3'd0;
               w_sh_nxt   = in_data;
               w_last_nxt = in_last;
            end else begin
               w_state_nxt = WAIT;
               w_stall_nxt = '0;
            end
         end

         WAIT: begin
            // An accept on the final allowed bubble cycle still wins.
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_bit_nxt   = 3'd0;
               w_sh_nxt    = in_data;
               w_last_nxt  = in_last;
            end else if (r_stall == STALL_LAST) begin
               w_state_nxt = END_STATE;
               w_gap_nxt   = '0;
               w_err_nxt   = 1'b1;
            end else begin
               w_stall_nxt = r_stall + 1'b1;
            end
         end

         GAP: begin
            if (r_gap == GAP_LAST) begin
               w_state_nxt = IDLE;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   // Output values for the state being entered.
   always_comb begin
      w_in_ready_nxt = 1'b0;
      w_dout_nxt     = 1'b0;
      w_valido_n_nxt = 1'b1;
      w_frameo_n_nxt = 1'b1;

      case (w_state_nxt)
         IDLE: w_in_ready_nxt = 1'b1;
         SHIFT: begin
            w_valido_n_nxt = 1'b0;
            w_dout_nxt     = w_sh_nxt[w_bit_nxt];
            // Frame ends during the last bit of the final byte.
            w_frameo_n_nxt = (w_bit_nxt == BIT_LAST) && w_last_nxt;
            w_in_ready_nxt = (w_bit_nxt == BIT_LAST) && !w_last_nxt;
         end
         WAIT: begin
            w_frameo_n_nxt = 1'b0;
            w_in_ready_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_bit      <= 3'd0;
         r_sh       <= '0;
         r_last     <= 1'b0;
         r_stall    <= '0;
         r_gap      <= '0;
         r_in_ready <= 1'b0;
         r_dout     <= 1'b0;
         r_valido_n <= 1'b1;
         r_frameo_n <= 1'b1;
         r_err      <= 1'b0;
         r_pkt_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_bit      <= w_bit_nxt;
         r_sh       <= w_sh_nxt;
         r_last     <= w_last_nxt;
         r_stall    <= w_stall_nxt;
         r_gap      <= w_gap_nxt;
         r_in_ready <= w_in_ready_nxt;
         r_dout     <= w_dout_nxt;
         r_valido_n <= w_valido_n_nxt;
         r_frameo_n <= w_frameo_n_nxt;
         r_err      <= w_err_nxt;
         r_pkt_cnt  <= w_pkt_nxt;
      end
   end

   assign in_ready     = r_in_ready;
   assign dout         = r_dout;
   assign valido_n     = r_valido_n;
   assign frameo_n     = r_frameo_n;
   assign err_underrun = r_err;
   assign pkt_cnt      = r_pkt_cnt;
   assign dbg_state    = r_state;

endmodule : router_oport_tx

// File: tb/tb_router_oport_tx.sv
// ---------------------------------------------------------------------------
// tb_router_oport_tx
// Bench for the output-port serializer. Three instances: dut0 with default
// parameters, dut1 with GAP_CYCLES=0 (own source), dut2 with CNT_W=2 driven by
// the same source as dut0 so its counter tracks dut0's packets.
// ---------------------------------------------------------------------------
module tb_router_oport_tx;
   import router_pkg::*;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // ---------------- DUT signals ----------------
   logic       in_valid, in_last;
   logic [7:0] in_data;
   logic       rdy0, dout0, von0, fon0, err0;
   logic [15:0] pkt0;
   tx_state_e  st0;

   logic       g_valid, g_last;
   logic [7:0] g_data;
   logic       rdy1, dout1, von1, fon1, err1;
   logic [15:0] pkt1;
   tx_state_e  st1;

   logic       rdy2, dout2, von2, fon2, err2;
   logic [1:0] pkt2;
   tx_state_e  st2;

   router_oport_tx #(.GAP_CYCLES(2), .STALL_MAX(16), .CNT_W(16)) dut0 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(rdy0), .dout(dout0), .valido_n(von0),
      .frameo_n(fon0), .err_underrun(err0), .pkt_cnt(pkt0), .dbg_state(st0));

   router_oport_tx #(.GAP_CYCLES(0), .STALL_MAX(16), .CNT_W(16)) dut1 (
      .clock(clock), .reset(reset), .in_valid(g_valid), .in_data(g_data),
      .in_last(g_last), .in_ready(rdy1), .dout(dout1), .valido_n(von1),
      .frameo_n(fon1), .err_underrun(err1), .pkt_cnt(pkt1), .dbg_state(st1));

   router_oport_tx #(.GAP_CYCLES(2), .STALL_MAX(16), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(rdy2), .dout(dout2), .valido_n(von2),
      .frameo_n(fon2), .err_underrun(err2), .pkt_cnt(pkt2), .dbg_state(st2));

   // ---------------- checking ----------------
   int n_pass  = 0;
   int n_total = 0;
   int exp_pkt = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // ---------------- trace recorder ----------------
   typedef struct {
      logic        vld;
      logic        rdy;
      logic        dout;
      logic        von;
      logic        fon;
      logic        err;
      logic [15:0] pkt;
      logic [1:0]  pkt2;
   } tr_t;

   tr_t  tr[$];
   logic rec_en  = 1'b0;
   logic rec_sel = 1'b0;

   always @(negedge clock) begin
      tr_t t;
      if (rec_en) begin
         if (!rec_sel) t = '{in_valid, rdy0, dout0, von0, fon0, err0, pkt0, pkt2};
         else          t = '{g_valid, rdy1, dout1, von1, fon1, err1, pkt1, 2'b00};
         tr.push_back(t);
      end
   end

   function automatic int first_valid();
      for (int i = 0; i < tr.size(); i++)
         if (tr[i].von == 1'b0) return i;
      return -1;
   endfunction

   // Serial bits in transmit order, first bit in the MSB.
   function automatic logic [7:0] bits8(input int s);
      logic [7:0] b = '0;
      for (int k = 0; k < 8; k++) b = {b[6:0], tr[s+k].dout};
      return b;
   endfunction

   function automatic int cnt_von_low(input int s, input int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (tr[s+k].von == 1'b0) c++;
      return c;
   endfunction

   function automatic int cnt_fon_high(input int s, input int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (tr[s+k].fon == 1'b1) c++;
      return c;
   endfunction

   // ---------------- scoreboard (random phase) ----------------
   logic [7:0] exp_q[$];
   logic       exp_last_q[$];
   logic       mon_en = 1'b0;
   logic [7:0] mon_byte = '0;
   int         mon_nb = 0;
   int         mon_err = 0;
   logic       mon_early = 1'b0;

   always @(negedge clock) begin
      if (mon_en) begin
         if (err0) mon_err++;
         if (!von0) begin
            mon_byte = {dout0, mon_byte[7:1]};
            mon_nb++;
            if (mon_nb < 8) begin
               if (fon0) mon_early = 1'b1;
            end else begin
               mon_nb = 0;
               if (exp_q.size() == 0) check("rnd_extra_byte", 32'd1, 32'd0);
               else begin
                  check("rnd_byte", mon_byte, exp_q.pop_front());
                  check("rnd_frame_end", fon0, exp_last_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] d, input logic l, input int pre);
      int n;
      repeat (pre) begin
         in_valid = 1'b0;
         cycle();
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      while (!rdy0 && n < 100) begin
         cycle();
         n++;
      end
      if (!rdy0) begin
         check("send_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      cycle();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic g_send(input logic [7:0] d);
      int n;
      g_valid = 1'b1;
      g_data  = d;
      g_last  = 1'b1;
      n = 0;
      while (!rdy1 && n < 100) begin
         cycle();
         n++;
      end
      if (!rdy1) begin
         check("g_send_timeout", 32'd0, 32'd1);
         g_valid = 1'b0;
         return;
      end
      cycle();
      g_valid = 1'b0;
   endtask

   // One single-byte packet on dut0, with framing, latency and counter checks.
   task automatic run_single(input string nm, input logic [7:0] d,
                             input logic [7:0] exp_bits, input logic [1:0] exp_p2);
      int i0;
      tr.delete();
      rec_sel = 1'b0;
      rec_en  = 1'b1;
      send_byte(d, 1'b1, 0);
      repeat (10) cycle();
      rec_en = 1'b0;
      i0 = first_valid();
      check({nm, "_found"}, 32'(i0 >= 0), 32'd1);
      if (i0 >= 0) begin
         exp_pkt++;
         check({nm, "_latency"}, 32'((i0 >= 1) && tr[i0-1].vld && tr[i0-1].rdy), 32'd1);
         check({nm, "_bits"}, bits8(i0), exp_bits);
         check({nm, "_valid_run"}, cnt_von_low(i0, 8), 32'd8);
         check({nm, "_frame_lo"}, cnt_fon_high(i0, 7), 32'd0);
         check({nm, "_frame_hi_b7"}, tr[i0+7].fon, 32'd1);
         check({nm, "_idle_after"}, tr[i0+8].von, 32'd1);
         check({nm, "_pkt_cnt"}, tr[i0+8].pkt, exp_pkt[15:0]);
         check({nm, "_pkt_cnt2"}, tr[i0+8].pkt2, exp_p2);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_bits;
      logic [1:0] exp_p2;
   } vec_t;

   vec_t vecs[6];

   // ---------------- main sequence ----------------
   initial begin
      int i0;
      int len, pre, errs, e_idx, waits;
      logic [7:0] d;

      vecs[0] = '{8'hA5, 8'hA5, 2'd1};
      vecs[1] = '{8'h01, 8'h80, 2'd2};
      vecs[2] = '{8'h80, 8'h01, 2'd3};
      vecs[3] = '{8'h0F, 8'hF0, 2'd0};
      vecs[4] = '{8'h06, 8'h60, 2'd1};
      vecs[5] = '{8'hC3, 8'hC3, 2'd2};

      reset = 1'b1;
      in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      g_valid = 1'b0;  g_data = 8'h00;  g_last = 1'b0;
      repeat (3) cycle();

      // Reset state
      check("rst_dout", dout0, 32'd0);
      check("rst_valido_n", von0, 32'd1);
      check("rst_frameo_n", fon0, 32'd1);
      check("rst_in_ready", rdy0, 32'd0);
      check("rst_err", err0, 32'd0);
      check("rst_pkt_cnt", pkt0, 32'd0);
      check("rst_state", st0, IDLE);
      reset = 1'b0;
      cycle();
      check("idle_in_ready", rdy0, 32'd1);

      // Two-byte packet {A5, 3C last}
      tr.delete(); rec_sel = 1'b0; rec_en = 1'b1;
      send_byte(8'hA5, 1'b0, 0);
      send_byte(8'h3C, 1'b1, 0);
      repeat (12) cycle();
      rec_en = 1'b0;
      exp_pkt++;
      i0 = first_valid();
      check("t1_found", 32'(i0 >= 0), 32'd1);
      if (i0 >= 0) begin
         check("t1_latency", 32'((i0 >= 1) && tr[i0-1].vld && tr[i0-1].rdy), 32'd1);
         check("t1_bits", {bits8(i0), bits8(i0+8)}, 32'hA53C);
         check("t1_valid_run", cnt_von_low(i0, 16), 32'd16);
         check("t1_frame_lo", cnt_fon_high(i0, 15), 32'd0);
         check("t1_frame_hi_last", tr[i0+15].fon, 32'd1);
         check("t1_idle_after", tr[i0+16].von, 32'd1);
         check("t1_rdy_b7_mid", tr[i0+7].rdy, 32'd1);
         check("t1_rdy_b7_last", tr[i0+15].rdy, 32'd0);
         check("t1_rdy_gap", {tr[i0+16].rdy, tr[i0+17].rdy}, 32'd0);
         check("t1_rdy_idle", tr[i0+18].rdy, 32'd1);
         check("t1_pkt_cnt", tr[i0+16].pkt, exp_pkt[15:0]);
      end

      // Source stalls three cycles after 0x01 of {01, FF last}
      tr.delete(); rec_en = 1'b1;
      send_byte(8'h01, 1'b0, 0);
      send_byte(8'hFF, 1'b1, 10);
      repeat (12) cycle();
      rec_en = 1'b0;
      exp_pkt++;
      i0 = first_valid();
      check("t2_found", 32'(i0 >= 0), 32'd1);
      if (i0 >= 0) begin
         check("t2_bits0", bits8(i0), 32'h80);
         waits = 0;
         for (int k = 8; k < 11; k++)
            if (tr[i0+k].von && !tr[i0+k].fon && !tr[i0+k].dout) waits++;
         check("t2_wait_cycles", waits, 32'd3);
         check("t2_resume", tr[i0+11].von, 32'd0);
         check("t2_bits1", bits8(i0+11), 32'hFF);
         check("t2_valid_run1", cnt_von_low(i0+11, 8), 32'd8);
         check("t2_frame_hi_last", tr[i0+18].fon, 32'd1);
         errs = 0;
         foreach (tr[k]) if (tr[k].err) errs++;
         check("t2_no_err", errs, 32'd0);
         check("t2_pkt_cnt", tr[i0+19].pkt, exp_pkt[15:0]);
      end

      // Stall past the limit: abort
      tr.delete(); rec_en = 1'b1;
      send_byte(8'h55, 1'b0, 0);
      repeat (32) cycle();
      rec_en = 1'b0;
      errs = 0; e_idx = -1; waits = 0;
      foreach (tr[k]) begin
         if (tr[k].err) begin errs++; e_idx = k; end
         if (tr[k].von && !tr[k].fon) waits++;
      end
      check("t3_err_pulses", errs, 32'd1);
      check("t3_wait_cycles", waits, 32'd16);
      if (e_idx >= 0) begin
         check("t3_err_frameo_n", tr[e_idx].fon, 32'd1);
         check("t3_err_valido_n", tr[e_idx].von, 32'd1);
         check("t3_err_in_ready", tr[e_idx].rdy, 32'd0);
      end
      check("t3_pkt_unchanged", pkt0, exp_pkt[15:0]);
      run_single("t3_next", 8'hC3, 8'hC3, 2'(exp_pkt + 1));

      // Randomized packets against the byte/packet scoreboard
      mon_nb = 0; mon_err = 0; mon_early = 1'b0; mon_en = 1'b1;
      for (int p = 0; p < 30; p++) begin
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            d   = 8'($urandom);
            pre = (b == 0) ? $urandom_range(0, 5) : $urandom_range(0, 12);
            exp_q.push_back(d);
            exp_last_q.push_back(b == len - 1);
            send_byte(d, b == len - 1, pre);
         end
         exp_pkt++;
      end
      repeat (20) cycle();
      mon_en = 1'b0;
      check("rnd_drain", exp_q.size(), 32'd0);
      check("rnd_frame_early", mon_early, 32'd0);
      check("rnd_no_err", mon_err, 32'd0);
      check("rnd_pkt_cnt", pkt0, exp_pkt[15:0]);
      check("rnd_pkt_cnt2", pkt2, 32'(exp_pkt % 4));

      // Reset at bit 4 of byte 2
      send_byte(8'h11, 1'b0, 0);
      in_valid = 1'b1; in_data = 8'h3F; in_last = 1'b0;
      repeat (8) cycle();
      in_valid = 1'b0;
      repeat (4) cycle();
      check("t4_mid_valid", von0, 32'd0);
      check("t4_mid_bit4", dout0, 32'd1);
      reset = 1'b1;
      cycle();
      check("t4_valido_n", von0, 32'd1);
      check("t4_frameo_n", fon0, 32'd1);
      check("t4_in_ready", rdy0, 32'd0);
      check("t4_dout", dout0, 32'd0);
      check("t4_pkt_cnt", pkt0, 32'd0);
      check("t4_pkt_cnt2", pkt2, 32'd0);
      reset = 1'b0;
      exp_pkt = 0;
      cycle();
      check("t4_ready_after", rdy0, 32'd1);

      // Vector table: single-byte packets; dut2 counter wraps 1,2,3,0,1,2
      for (int v = 0; v < 6; v++)
         run_single($sformatf("vec%0d", v), vecs[v].data, vecs[v].exp_bits, vecs[v].exp_p2);

      // Back-to-back single-byte packets with GAP_CYCLES=0 (dut1)
      tr.delete(); rec_sel = 1'b1; rec_en = 1'b1;
      g_send(8'h80);
      g_send(8'h01);
      repeat (12) cycle();
      rec_en = 1'b0;
      i0 = first_valid();
      check("t5_found", 32'(i0 >= 0), 32'd1);
      if (i0 >= 0) begin
         check("t5_bits_a", bits8(i0), 32'h01);
         check("t5_frame_hi_a", tr[i0+7].fon, 32'd1);
         check("t5_rdy_b7", tr[i0+7].rdy, 32'd0);
         check("t5_between", {tr[i0+8].von, tr[i0+8].fon, tr[i0+8].rdy}, 32'b111);
         check("t5_start_b", {tr[i0+9].von, tr[i0+9].fon}, 32'b00);
         check("t5_bits_b", bits8(i0+9), 32'h80);
         check("t5_frame_hi_b", tr[i0+16].fon, 32'd1);
         check("t5_pkt_cnt", tr[i0+17].pkt, 32'd2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule : tb_router_oport_tx
